// File: rtl/pll_drp_pkg.sv
// Shared types for the PLL DRP reconfiguration sequencer: FSM states, ROM entry layout, bus widths.
// The read-modify-write merge rule is kept here so the ROM contents and the sequencer agree on mask polarity.
package pll_drp_pkg;

  localparam int DADDR_W = 5;
  localparam int DATA_W  = 16;
  localparam int CFG_W   = 4;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE, RD, WRD, WR, WWR, REL, WLK, DONE
  } state_t;

  typedef struct packed {
    logic [DADDR_W-1:0] addr;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  data;
  } rom_entry_t;

  // mask bit = 1 keeps the bit already in the PLL
  function automatic logic [DATA_W-1:0] drp_merge(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] mask,
                                                  input logic [DATA_W-1:0] data);
    return (old_v & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_drp_rom.sv
// Per-config DRP table: config k programs CLKOUT0_DIVIDE=k+1 with M=8, D=1 and lock settings fixed.
// Purely combinational; entries past the table keep every PLL bit.
module pll_drp_rom
  import pll_drp_pkg::*;
(
  input  logic [CFG_W-1:0] cfg,
  input  logic [IDX_W-1:0] idx,
  output rom_entry_t       ent
);

  logic [4:0] div;
  logic [5:0] hi_t;
  logic [5:0] lo_t;

  always_comb begin
    div  = {1'b0, cfg} + 5'd1;
    hi_t = {2'b00, div[4:1]};
    lo_t = {1'b0, div} - hi_t;
    ent  = '{addr: 5'h00, mask: 16'hFFFF, data: 16'h0000};
    case (idx)
      // CLKOUT0 high/low time, then edge / no-count for odd and bypass divides
      4'd0: ent = '{addr: 5'h08, mask: 16'hF000, data: {4'h0, hi_t, lo_t}};
      4'd1: ent = '{addr: 5'h09, mask: 16'hFF3F, data: {8'h00, div[0], (div == 5'd1), 6'h00}};
      4'd2: ent = '{addr: 5'h14, mask: 16'hF000, data: 16'h0104};
      4'd3: ent = '{addr: 5'h15, mask: 16'hFF3F, data: 16'h0000};
      4'd4: ent = '{addr: 5'h16, mask: 16'hC000, data: 16'h1041};
      4'd5: ent = '{addr: 5'h18, mask: 16'hFC00, data: 16'h01E8};
      4'd6: ent = '{addr: 5'h19, mask: 16'h8000, data: 16'h7C01};
      4'd7: ent = '{addr: 5'h1A, mask: 16'h8000, data: 16'h7FE9};
      default: ;
    endcase
  end

endmodule

// File: rtl/pll_drp_seq.sv
// PLL DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes NREG registers, waits for lock.
// Zero-wait DRP: 4 cycles per register; one DRP access outstanding at a time; SEN ignored while busy.
module pll_drp_seq
  import pll_drp_pkg::*;
#(
  parameter int NREG    = 8,
  parameter int DRDY_TO = 64,
  parameter int LOCK_TO = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [CFG_W-1:0]   SADDR,
  input  logic               SEN,
  output logic               SRDY,
  output logic               ERR,
  input  logic [DATA_W-1:0]  DO,
  input  logic               DRDY,
  input  logic               LOCKED,
  output logic               DWE,
  output logic               DEN,
  output logic [DADDR_W-1:0] DADDR,
  output logic [DATA_W-1:0]  DI,
  output logic               DCLK,
  output logic               RST_PLL
);

  localparam int TMAX  = (LOCK_TO > DRDY_TO) ? LOCK_TO : DRDY_TO;
  localparam int TMR_W = $clog2(TMAX) + 1;
  localparam logic [TMR_W-1:0] DRDY_LAST = TMR_W'(DRDY_TO - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TO - 1);
  localparam logic [TMR_W-1:0] TMR_SAT   = '1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREG - 1);

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q;
  logic               err_d, rst_pll_d;
  logic [DATA_W-1:0]  di_d;
  rom_entry_t         ent;

  assign DCLK = CLK;

  // Lookup uses next cfg/idx so DADDR can be registered on entry to RD
  pll_drp_rom u_rom (
    .cfg (cfg_d),
    .idx (idx_d),
    .ent (ent)
  );

  always_comb begin
    cfg_d = cfg_q;
    idx_d = idx_q;
    if (state_q == IDLE && SEN) begin
      cfg_d = SADDR;
      idx_d = '0;
    end else if (state_q == WWR && DRDY && idx_q != IDX_LAST) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = ERR;
    rst_pll_d = RST_PLL;
    di_d      = DI;
    case (state_q)
      IDLE: if (SEN) begin
        err_d     = 1'b0;
        rst_pll_d = 1'b1;
        state_d   = RD;
      end
      RD:   state_d = WRD;
      WRD: begin
        if (DRDY) begin
          di_d    = drp_merge(DO, ent.mask, ent.data);
          state_d = WR;
        end else if (tmr_q == DRDY_LAST) begin
          err_d     = 1'b1;
          rst_pll_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WR:   state_d = WWR;
      WWR: begin
        if (DRDY) begin
          if (idx_q == IDX_LAST) begin
            rst_pll_d = 1'b0;
            state_d   = REL;
          end else begin
            state_d = RD;
          end
        end else if (tmr_q == DRDY_LAST) begin
          err_d     = 1'b1;
          rst_pll_d = 1'b0;
          state_d   = IDLE;
        end
      end
      REL:  state_d = WLK;
      WLK: begin
        if (LOCKED) begin
          state_d = DONE;
        end else if (tmr_q == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      SRDY    <= 1'b0;
      ERR     <= 1'b0;
      DEN     <= 1'b0;
      DWE     <= 1'b0;
      DADDR   <= '0;
      DI      <= '0;
      RST_PLL <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      if (state_d != state_q) tmr_q <= '0;
      else if (tmr_q != TMR_SAT) tmr_q <= tmr_q + TMR_W'(1);
      SRDY    <= (state_d == DONE);
      ERR     <= err_d;
      DEN     <= (state_d == RD) || (state_d == WR);
      DWE     <= (state_d == WR);
      if (state_d == RD) DADDR <= ent.addr;
      DI      <= di_d;
      RST_PLL <= rst_pll_d;
    end
  end

endmodule

// File: tb/tb_pll_drp_seq.sv
// Bench for pll_drp_seq: behavioural DRP register file + PLL lock model, table-driven expected image.
module tb_pll_drp_seq;
  localparam int NREG    = 8;
  localparam int DRDY_TO = 64;
  localparam int LOCK_TO = 300;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SEN = 1'b0;
  logic [3:0]  SADDR = 4'h0;
  logic [15:0] DO = 16'h0;
  logic        DRDY = 1'b0;
  logic        LOCKED = 1'b0;
  logic        SRDY, ERR, DWE, DEN, DCLK, RST_PLL;
  logic [4:0]  DADDR;
  logic [15:0] DI;

  pll_drp_seq #(.NREG(NREG), .DRDY_TO(DRDY_TO), .LOCK_TO(LOCK_TO)) dut (
    .CLK(CLK), .RST(RST), .SADDR(SADDR), .SEN(SEN), .SRDY(SRDY), .ERR(ERR),
    .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED), .DWE(DWE), .DEN(DEN), .DADDR(DADDR),
    .DI(DI), .DCLK(DCLK), .RST_PLL(RST_PLL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  // knobs written by the directed sequence
  int          lat = 1, drop_abs = -1, lock_mode = 0, lock_dly = 10;
  int          load_seq = 0, stray_seq = 0;
  logic [15:0] new_img [32];
  logic [15:0] exp_regs [32];

  // model state
  logic [15:0] pll_regs [32];
  int  load_done = 0, stray_done = 0, cnt = 0, den_total = 0, proto_err = 0, srdy_total = 0;
  int  fall_cyc = 0, srdy_cyc = 0, err_cyc = 0, drop_cyc = 0, lock_cnt = 0;
  bit  pend = 0, expect_wr = 0, den_prev = 0, srdy_prev = 0, rst_prev = 0, err_prev = 0, cur_we = 0;
  logic [4:0] cur_addr = 5'h0;

  always @(negedge CLK) begin
    DRDY = 1'b0;
    if (load_seq != load_done) begin
      for (int i = 0; i < 32; i++) pll_regs[i] = new_img[i];
      load_done = load_seq; pend = 0; expect_wr = 0;
    end
    if (RST) pend = 0;
    if (DEN && pend) proto_err++;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        DRDY = 1'b1; pend = 0;
        if (!cur_we) DO = pll_regs[cur_addr];
      end
    end
    if (DEN) begin
      if (den_prev || !RST_PLL) proto_err++;
      if (DWE) begin
        if (!expect_wr || DADDR != cur_addr) proto_err++;
        pll_regs[DADDR] = DI; expect_wr = 0;
      end else begin
        if (expect_wr) proto_err++;
        expect_wr = 1;
      end
      cur_addr = DADDR; cur_we = DWE;
      den_total++;
      if (den_total == drop_abs) drop_cyc = cyc;
      else begin pend = 1; cnt = lat; end
      if (stray_seq != stray_done && !DWE) begin
        DRDY = 1'b1; DO = 16'($urandom); stray_done = stray_seq;
      end
    end
    den_prev = DEN;
    if (SRDY) begin srdy_total++; srdy_cyc = cyc; if (srdy_prev) proto_err++; end
    srdy_prev = SRDY;
    if (rst_prev && !RST_PLL) fall_cyc = cyc;
    rst_prev = RST_PLL;
    if (ERR && !err_prev) err_cyc = cyc;
    err_prev = ERR;
    if (lock_mode == 2) LOCKED = 1'b1;
    else if (lock_mode == 1) LOCKED = 1'b0;
    else if (RST_PLL) begin lock_cnt = 0; LOCKED = 1'b0; end
    else begin
      if (lock_cnt < 1000000) lock_cnt++;
      LOCKED = (lock_cnt >= lock_dly);
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference table: divide d=cfg+1 split into high/low counts, fixed M=8/D=1/lock words
  task automatic ref_entry(input int cfg, input int i, output logic [4:0] a,
                           output logic [15:0] m, output logic [15:0] d);
    int dv;
    dv = cfg + 1;
    a = 5'h0; m = 16'hFFFF; d = 16'h0;
    case (i)
      0: begin a = 5'h08; m = 16'hF000; d = 16'((dv / 2) * 64 + (dv - dv / 2)); end
      1: begin a = 5'h09; m = 16'hFF3F; d = 16'((dv % 2) * 128 + ((dv == 1) ? 64 : 0)); end
      2: begin a = 5'h14; m = 16'hF000; d = 16'(4 * 64 + 4); end
      3: begin a = 5'h15; m = 16'hFF3F; d = 16'h0000; end
      4: begin a = 5'h16; m = 16'hC000; d = 16'h1000 + 16'd65; end
      5: begin a = 5'h18; m = 16'hFC00; d = 16'h01E8; end
      6: begin a = 5'h19; m = 16'h8000; d = 16'h7C01; end
      7: begin a = 5'h1A; m = 16'h8000; d = 16'h7FE9; end
      default: ;
    endcase
  endtask

  task automatic ref_apply(input int cfg, input int upto);
    logic [4:0] a; logic [15:0] m, d;
    for (int i = 0; i < upto; i++) begin
      ref_entry(cfg, i, a, m, d);
      exp_regs[a] = (exp_regs[a] & m) | (d & ~m);
    end
  endtask

  task automatic chk_image(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s[%0d]", tag, i), 32'(pll_regs[i]), 32'(exp_regs[i]));
  endtask

  task automatic step();
    @(negedge CLK); #1;
  endtask

  task automatic load_image();
    for (int i = 0; i < 32; i++) begin
      new_img[i] = 16'($urandom); exp_regs[i] = new_img[i];
    end
    load_seq++;
    step(); step();
  endtask

  task automatic pulse_sen(input int cfg, output int s);
    SADDR = 4'(cfg); SEN = 1'b1; s = cyc;
    step();
    SEN = 1'b0; SADDR = 4'($urandom);
  endtask

  task automatic wait_end(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (SRDY || ERR) begin seen = 1; break; end
      step();
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_SRDY"}, SRDY, 0); chk({tag, "_ERR"}, ERR, 0); chk({tag, "_DEN"}, DEN, 0);
    chk({tag, "_DWE"}, DWE, 0); chk({tag, "_DADDR"}, DADDR, 0); chk({tag, "_DI"}, DI, 0);
    chk({tag, "_RST_PLL"}, RST_PLL, 0);
  endtask

  // Full successful reconfiguration with timing derived from DRP latency and lock delay
  task automatic run_cfg(input int cfg, input int l, input int dly, input bit stray);
    int s, srdy0, den0; bit seen;
    lat = l; lock_dly = dly;
    load_image();
    srdy0 = srdy_total; den0 = den_total;
    if (stray) stray_seq++;
    pulse_sen(cfg, s);
    chk("err_clr", ERR, 0); chk("rst_pll_on", RST_PLL, 1);
    wait_end(4000, seen);
    chk("end_seen", 32'(seen), 1); chk("err_ok", ERR, 0); chk("srdy", SRDY, 1);
    chk("fall_t", 32'(fall_cyc - s), 32'(1 + 2 * NREG * (1 + l)));
    chk("srdy_t", 32'(srdy_cyc - fall_cyc), 32'((dly < 2) ? 2 : dly));
    step();
    chk("srdy_1cyc", SRDY, 0);
    chk("srdy_cnt", 32'(srdy_total - srdy0), 1);
    chk("den_cnt", 32'(den_total - den0), 32'(2 * NREG));
    chk("proto", 32'(proto_err), 0);
    ref_apply(cfg, NREG);
    chk_image($sformatf("img_c%0d", cfg));
  endtask

  initial begin
    int s, d, srdy0, den0; bit seen;
    // reset state
    repeat (3) step();
    chk_reset_outs("rst");
    chk("dclk_lo", DCLK, CLK);
    @(posedge CLK); #1;
    chk("dclk_hi", DCLK, 1);
    RST = 1'b0;
    step();

    // nominal cfg 3, zero-wait DRP, lock after 10 cycles
    run_cfg(3, 1, 10, 0);
    // slow DRP with a stray DRDY during the first read
    run_cfg(3, 5, 10, 1);

    // SEN while busy, and on the DONE cycle, is ignored
    lat = 2; lock_dly = 10;
    load_image();
    srdy0 = srdy_total; den0 = den_total;
    pulse_sen(3, s);
    for (int k = 0; k < 6; k++) begin
      repeat (7) step();
      SADDR = 4'd9; SEN = 1'b1; step(); SEN = 1'b0;
    end
    wait_end(400, seen);
    chk("busy_seen", 32'(seen), 1); chk("busy_srdy", SRDY, 1);
    SADDR = 4'd9; SEN = 1'b1; step(); SEN = 1'b0;
    repeat (20) step();
    chk("busy_srdy_cnt", 32'(srdy_total - srdy0), 1);
    chk("busy_den_cnt", 32'(den_total - den0), 32'(2 * NREG));
    chk("busy_rst_pll", RST_PLL, 0);
    ref_apply(3, NREG);
    chk_image("img_busy");

    // DRDY never returned on the third access
    lat = 1;
    load_image();
    srdy0 = srdy_total; den0 = den_total;
    drop_abs = den_total + 3;
    pulse_sen(3, s);
    wait_end(400, seen);
    chk("drto_seen", 32'(seen), 1); chk("drto_err", ERR, 1); chk("drto_rst_pll", RST_PLL, 0);
    d = err_cyc - drop_cyc;
    chk("drto_time_ok", 32'((d >= DRDY_TO) && (d <= DRDY_TO + 2)), 1);
    repeat (10) step();
    chk("drto_sticky", ERR, 1);
    chk("drto_no_srdy", 32'(srdy_total - srdy0), 0);
    chk("drto_den_cnt", 32'(den_total - den0), 3);
    ref_apply(3, 1);
    chk_image("img_partial");
    drop_abs = -1;
    run_cfg(3, 1, 10, 0);

    // LOCKED never rises
    lock_mode = 1;
    load_image();
    srdy0 = srdy_total;
    pulse_sen(7, s);
    wait_end(LOCK_TO + 400, seen);
    chk("lkto_seen", 32'(seen), 1); chk("lkto_err", ERR, 1); chk("lkto_rst_pll", RST_PLL, 0);
    d = err_cyc - fall_cyc;
    chk("lkto_time_ok", 32'((d >= LOCK_TO - 1) && (d <= LOCK_TO + 3)), 1);
    step();
    chk("lkto_no_srdy", 32'(srdy_total - srdy0), 0);
    ref_apply(7, NREG);
    chk_image("img_lkto");
    // LOCKED already high when the PLL is released
    lock_mode = 2;
    run_cfg($urandom_range(0, 15), 1, 1, 0);
    lock_mode = 0;

    // reset in the middle of a write
    lat = 1;
    load_image();
    pulse_sen(4, s);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (DEN && DWE) begin seen = 1; break; end
      step();
    end
    chk("wr_seen", 32'(seen), 1);
    RST = 1'b1;
    step();
    chk_reset_outs("midrst");
    RST = 1'b0;
    step();
    run_cfg(15, 1, 10, 0);

    // randomized configs, DRP latencies and lock delays
    for (int k = 0; k < 4; k++)
      run_cfg($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(1, 12), 0);

    chk("proto_total", 32'(proto_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
